// File: rtl/bi_row_arbiter_if.sv
// Handshake bundle between NREQ row producers, the round-robin arbiter and
// the shared bi_model_sv row serializer.
interface bi_row_arbiter_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int HOUT           = 56,
    parameter int ROWID_WIDTH    = 6,
    parameter int NREQ           = 2,
    parameter int ROWS_PER_FRAME = 56
);
    localparam int CNT_W = $clog2(ROWS_PER_FRAME) + 1;

    logic                   en;
    logic [NREQ-1:0]        req;
    logic [ROWID_WIDTH-1:0] req_rowID [NREQ];
    logic [DATA_WIDTH-1:0]  req_data  [NREQ][HOUT];
    logic [NREQ-1:0]        gnt;
    logic                   ser_ready;
    logic                   data_valid;
    logic [ROWID_WIDTH-1:0] rowID;
    logic [DATA_WIDTH-1:0]  data_temp [HOUT];
    logic                   busy;
    logic [CNT_W-1:0]       row_count;
    logic                   frame_done;

    modport master (
        input  en, req, req_rowID, req_data, ser_ready,
        output gnt, data_valid, rowID, data_temp, busy, row_count, frame_done
    );

    modport slave (
        output en, req, req_rowID, req_data, ser_ready,
        input  gnt, data_valid, rowID, data_temp, busy, row_count, frame_done
    );
endinterface

// File: rtl/bi_row_arbiter.sv
// Round-robin sequencer feeding one row serializer from NREQ producers; issues
// a row, waits for the serializer's ready low/high cycle, and counts frame rows.
module bi_row_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int HOUT           = 56,
    parameter int ROWID_WIDTH    = 6,
    parameter int NREQ           = 2,
    parameter int ROWS_PER_FRAME = 56
) (
    input  logic             clk,
    input  logic             rstn,
    bi_row_arbiter_if.master bus
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(ROWS_PER_FRAME) + 1;

    typedef enum logic [1:0] {ARB, WAIT_LO, WAIT_HI} state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] winner;
    logic             found;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.req[(int'(ptr) + i) % NREQ]) begin
                found  = 1'b1;
                winner = PTR_W'((int'(ptr) + i) % NREQ);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= ARB;
            ptr            <= '0;
            bus.gnt        <= '0;
            bus.data_valid <= 1'b0;
            bus.rowID      <= '0;
            // NOTE: the row register is reset because it drives the serializer
            // directly and must read as zero before the first grant.
            bus.data_temp  <= '{default: '0};
            bus.busy       <= 1'b0;
            bus.row_count  <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.gnt        <= '0;
            bus.data_valid <= 1'b0;
            bus.frame_done <= 1'b0;
            case (state)
                ARB: begin
                    if (bus.en && bus.ser_ready && found) begin
                        bus.gnt        <= NREQ'(1) << winner;
                        bus.data_valid <= 1'b1;
                        bus.rowID      <= bus.req_rowID[winner];
                        bus.data_temp  <= bus.req_data[winner];
                        ptr            <= (winner == PTR_W'(NREQ - 1)) ? '0 : winner + 1'b1;
                        bus.busy       <= 1'b1;
                        // Wrap on the frame's last row so the count never shows ROWS_PER_FRAME.
                        if (bus.row_count == CNT_W'(ROWS_PER_FRAME - 1)) begin
                            bus.row_count  <= '0;
                            bus.frame_done <= 1'b1;
                        end else begin
                            bus.row_count <= bus.row_count + 1'b1;
                        end
                        state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!bus.ser_ready) state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (bus.ser_ready) begin
                        bus.busy <= 1'b0;
                        state    <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end
endmodule

// File: tb/tb_bi_row_arbiter.sv
// Directed bench for bi_row_arbiter with a behavioural serializer that drops
// ready after each data_valid and raises it again a fixed number of cycles later.
module tb_bi_row_arbiter;
    localparam int DW   = 8;
    localparam int HOUT = 56;
    localparam int RW   = 6;
    localparam int NREQ = 2;
    localparam int RPF  = 3;
    localparam int SER_BUSY = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic model_ready = 1'b1;
    logic ser_force_lo = 1'b0;
    int   busy_cnt = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    bi_row_arbiter_if #(.DATA_WIDTH(DW), .HOUT(HOUT), .ROWID_WIDTH(RW),
                        .NREQ(NREQ), .ROWS_PER_FRAME(RPF)) bus ();

    bi_row_arbiter #(.DATA_WIDTH(DW), .HOUT(HOUT), .ROWID_WIDTH(RW),
                     .NREQ(NREQ), .ROWS_PER_FRAME(RPF)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.ser_ready = model_ready & ~ser_force_lo;

    // Serializer model: ready drops the cycle after data_valid, returns SER_BUSY cycles later.
    always @(negedge clk) begin
        if (!rstn) begin
            model_ready = 1'b1;
            busy_cnt    = 0;
        end else if (busy_cnt != 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) model_ready = 1'b1;
        end else if (bus.data_valid) begin
            model_ready = 1'b0;
            busy_cnt    = SER_BUSY;
        end
    end

    task automatic set_row(input int r, input int id, input int seed);
        bus.req_rowID[r] = RW'(id);
        for (int k = 0; k < HOUT; k++) bus.req_data[r][k] = DW'(seed + k);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        bus.en = 1'b0;
        bus.req = '0;
        ser_force_lo = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic wait_issue(input int budget, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (bus.data_valid) seen = 1'b1;
        end
    endtask

    task automatic wait_idle(input int budget, output bit seen, output int dv_cnt);
        seen = 1'b0;
        dv_cnt = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (bus.data_valid) dv_cnt++;
            if (!bus.busy) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        int nz;
        @(negedge clk);
        rstn = 1'b0;
        bus.en = 1'b0;
        bus.req = '0;
        repeat (2) @(negedge clk);
        nz = 0;
        for (int k = 0; k < HOUT; k++) if (bus.data_temp[k] !== '0) nz++;
        n_checks++;
        if ({bus.gnt, bus.data_valid, bus.rowID, bus.busy, bus.row_count, bus.frame_done} !== '0 || nz != 0)
            $display("FAIL reset_outputs: gnt=%b dv=%b rowID=%0d busy=%b cnt=%0d fd=%b nonzero_data=%0d, required all zero",
                     bus.gnt, bus.data_valid, bus.rowID, bus.busy, bus.row_count, bus.frame_done, nz);
        else n_pass++;
        rstn = 1'b1;
    endtask

    task automatic test_single();
        int bad, dvc;
        bit seen;
        do_reset();
        set_row(0, 5, 0);
        bus.req = 2'b01;
        bus.en = 1'b1;
        @(negedge clk);
        bad = 0;
        for (int k = 0; k < HOUT; k++) if (bus.data_temp[k] !== DW'(k)) bad++;
        n_checks++;
        if (bus.gnt !== 2'b01 || bus.data_valid !== 1'b1 || bus.rowID !== RW'(5) || bad != 0)
            $display("FAIL single_issue: gnt=%b dv=%b rowID=%0d bad_elems=%0d, required gnt=01 dv=1 rowID=5 bad_elems=0",
                     bus.gnt, bus.data_valid, bus.rowID, bad);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.row_count !== 3'd1)
            $display("FAIL single_busy_count: busy=%b cnt=%0d, required busy=1 cnt=1", bus.busy, bus.row_count);
        else n_pass++;
        bus.req = '0;
        wait_idle(40, seen, dvc);
        n_checks++;
        if (!seen || bus.ser_ready !== 1'b1)
            $display("FAIL single_busy_clear: idle_seen=%b ready=%b, required 1/1", seen, bus.ser_ready);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int bad, dvc, w;
        bit seen;
        do_reset();
        set_row(0, 10, 3);
        set_row(1, 20, 100);
        bus.req = 2'b11;
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = i % 2;
            wait_issue(40, seen);
            bad = 0;
            for (int k = 0; k < HOUT; k++)
                if (bus.data_temp[k] !== DW'((w == 0 ? 3 : 100) + k)) bad++;
            n_checks++;
            if (!seen || bus.gnt !== NREQ'(1 << w) || bus.rowID !== RW'(w == 0 ? 10 : 20) || bad != 0)
                $display("FAIL rr_grant_%0d: seen=%b gnt=%b rowID=%0d bad_elems=%0d, required gnt=%b rowID=%0d",
                         i, seen, bus.gnt, bus.rowID, bad, NREQ'(1 << w), (w == 0 ? 10 : 20));
            else n_pass++;
            wait_idle(40, seen, dvc);
            n_checks++;
            if (!seen || dvc != 0)
                $display("FAIL rr_single_pulse_%0d: idle_seen=%b extra_dv=%0d, required 1/0", i, seen, dvc);
            else n_pass++;
        end
    endtask

    task automatic test_ready_stall();
        int hits;
        do_reset();
        set_row(0, 7, 50);
        ser_force_lo = 1'b1;
        bus.req = 2'b01;
        bus.en = 1'b1;
        hits = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.data_valid || bus.gnt != '0) hits++;
        end
        n_checks++;
        if (hits != 0) $display("FAIL stall_no_grant: pulses=%0d, required 0", hits);
        else n_pass++;
        ser_force_lo = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.gnt !== 2'b01 || bus.data_valid !== 1'b1)
            $display("FAIL stall_release: gnt=%b dv=%b, required 01/1", bus.gnt, bus.data_valid);
        else n_pass++;
    endtask

    task automatic test_frame();
        bit seen;
        int exp_cnt;
        do_reset();
        set_row(0, 1, 9);
        bus.req = 2'b01;
        bus.en = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            exp_cnt = i % RPF;
            wait_issue(40, seen);
            n_checks++;
            if (!seen || bus.row_count !== 3'(exp_cnt) || bus.frame_done !== (exp_cnt == 0))
                $display("FAIL frame_row_%0d: seen=%b cnt=%0d fd=%b, required cnt=%0d fd=%b",
                         i, seen, bus.row_count, bus.frame_done, exp_cnt, (exp_cnt == 0));
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (bus.frame_done !== 1'b0) $display("FAIL frame_done_pulse: fd=%b, required 0", bus.frame_done);
        else n_pass++;
    endtask

    task automatic test_enable();
        bit seen;
        int dvc, hits;
        do_reset();
        set_row(0, 11, 0);
        set_row(1, 22, 40);
        bus.req = 2'b01;
        bus.en = 1'b1;
        wait_issue(10, seen);
        bus.req = '0;
        wait_idle(40, seen, dvc);
        bus.en = 1'b0;
        bus.req = 2'b11;
        hits = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.data_valid || bus.gnt != '0) hits++;
        end
        n_checks++;
        if (hits != 0) $display("FAIL en_low_no_grant: pulses=%0d, required 0", hits);
        else n_pass++;
        bus.en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.gnt !== 2'b10 || bus.data_valid !== 1'b1 || bus.rowID !== RW'(22))
            $display("FAIL en_raise_ptr: gnt=%b dv=%b rowID=%0d, required 10/1/22", bus.gnt, bus.data_valid, bus.rowID);
        else n_pass++;
        repeat (2) @(negedge clk);
        bus.en = 1'b0;
        wait_idle(40, seen, dvc);
        n_checks++;
        if (!seen) $display("FAIL en_drop_completes: busy=%b, required 0", bus.busy);
        else n_pass++;
        hits = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.data_valid || bus.busy) hits++;
        end
        n_checks++;
        if (hits != 0) $display("FAIL en_drop_stalls: active_cycles=%0d, required 0", hits);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset();
        set_row(0, 33, 60);
        set_row(1, 44, 70);
        bus.req = 2'b01;
        bus.en = 1'b1;
        wait_issue(10, seen);
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({bus.gnt, bus.data_valid, bus.rowID, bus.busy, bus.row_count, bus.frame_done} !== '0
            || bus.data_temp[HOUT-1] !== '0)
            $display("FAIL mid_reset_clear: seen=%b gnt=%b dv=%b rowID=%0d busy=%b cnt=%0d, required all zero",
                     seen, bus.gnt, bus.data_valid, bus.rowID, bus.busy, bus.row_count);
        else n_pass++;
        bus.req = 2'b10;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.gnt !== '0 || bus.data_valid !== 1'b0)
            $display("FAIL mid_reset_quiet: gnt=%b dv=%b, required 00/0", bus.gnt, bus.data_valid);
        else n_pass++;
        rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.gnt !== 2'b10 || bus.data_valid !== 1'b1 || bus.rowID !== RW'(44))
            $display("FAIL mid_reset_regrant: gnt=%b dv=%b rowID=%0d, required 10/1/44", bus.gnt, bus.data_valid, bus.rowID);
        else n_pass++;
    endtask

    initial begin
        bus.en = 1'b0;
        bus.req = '0;
        for (int r = 0; r < NREQ; r++) set_row(r, 0, 0);
        test_reset();
        test_single();
        test_round_robin();
        test_ready_stall();
        test_frame();
        test_enable();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
